// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared state encoding, widths and helpers for the SPI request arbiter
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2,
    RESP  = 2'd3
  } spi_arb_state_t;

  localparam int SPI_DATA_W = 8;

  // Never returns less than 1 so a 1-bit index still has a legal width.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/spi_rr_pick.sv
// rtl/spi_rr_pick.sv - combinational round-robin picker: first set req bit at or after ptr
module spi_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] onehot,
  output logic [IDX_W-1:0]   idx,
  output logic               valid
);

  int pos;

  // Walk the search order backwards so the candidate closest to ptr is written last.
  always_comb begin
    onehot = '0;
    idx    = '0;
    valid  = 1'b0;
    pos    = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      pos = (int'(ptr) + k) % NUM_REQ;
      if (req[pos]) begin
        onehot      = '0;
        onehot[pos] = 1'b1;
        idx         = IDX_W'(pos);
        valid       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_req_arbiter.sv
// rtl/spi_req_arbiter.sv - round-robin sharing of one spi_master among NUM_REQ requesters
// Optional BUSY watchdog enabled by SPI_ARB_TIMEOUT_EN.
module spi_req_arbiter
  import spi_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = SPI_DATA_W,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] tx_data,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        ack,
  output logic [DATA_W-1:0]         rx_data,
  output logic                      busy,
  output logic                      err,
  output logic                      m_start,
  output logic [DATA_W-1:0]         m_tx_data,
  input  logic                      m_done,
  input  logic [DATA_W-1:0]         m_rx_data
);

  localparam int IDX_W = clog2(NUM_REQ);

  spi_arb_state_t     state;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   idx;
  logic [IDX_W-1:0]   pick_idx;
  logic [NUM_REQ-1:0] pick_onehot;
  logic               pick_valid;
  logic               tmo_hit;

  spi_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req    (req),
    .ptr    (ptr),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .valid  (pick_valid)
  );

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int TMO_W = clog2(TIMEOUT_CYC);
  logic [TMO_W-1:0] tmo_cnt;
  assign tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
`else
  assign tmo_hit = 1'b0;
  assign err     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      idx       <= '0;
      gnt       <= '0;
      ack       <= '0;
      rx_data   <= '0;
      busy      <= 1'b0;
      m_start   <= 1'b0;
      m_tx_data <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
      tmo_cnt   <= '0;
      err       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            idx       <= pick_idx;
            gnt       <= pick_onehot;
            m_tx_data <= tx_data[pick_idx*DATA_W +: DATA_W];
            m_start   <= 1'b1;
            busy      <= 1'b1;
            state     <= START;
          end
        end
        START: begin
          m_start <= 1'b0;
          state   <= BUSY;
        end
        BUSY: begin
          // A real completion wins over a watchdog expiry in the same cycle.
          if (m_done || tmo_hit) begin
            rx_data <= m_done ? m_rx_data : '1;
            ack     <= gnt;
            ptr     <= (idx == IDX_W'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
            state   <= RESP;
`ifdef SPI_ARB_TIMEOUT_EN
            err     <= ~m_done;
            tmo_cnt <= '0;
`endif
          end
`ifdef SPI_ARB_TIMEOUT_EN
          else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end
        RESP: begin
          ack   <= '0;
          gnt   <= '0;
          busy  <= 1'b0;
          state <= IDLE;
`ifdef SPI_ARB_TIMEOUT_EN
          err   <= 1'b0;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_req_arbiter.sv
// tb/tb_spi_req_arbiter.sv - self-checking bench for spi_req_arbiter
module tb_spi_req_arbiter;

  localparam int N   = 4;
  localparam int DW  = 8;
  localparam int TMO = 16;

  logic          clk;
  logic          rst_n;
  logic [N-1:0]  req;
  logic [N*DW-1:0] tx_data;
  logic [N-1:0]  gnt;
  logic [N-1:0]  ack;
  logic [DW-1:0] rx_data;
  logic          busy;
  logic          err;
  logic          m_start;
  logic [DW-1:0] m_tx_data;
  logic          m_done;
  logic [DW-1:0] m_rx_data;

  spi_req_arbiter #(.NUM_REQ(N), .DATA_W(DW), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .tx_data(tx_data),
    .gnt(gnt), .ack(ack), .rx_data(rx_data), .busy(busy), .err(err),
    .m_start(m_start), .m_tx_data(m_tx_data),
    .m_done(m_done), .m_rx_data(m_rx_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Master model: answers each m_start after m_dly cycles with m_resp.
  bit          m_auto = 1'b1;
  bit          spur   = 1'b0;
  int          m_dly  = 1;
  logic [7:0]  m_resp = '0;
  bit          pend   = 1'b0;
  int          cnt    = 0;
  int          done_cyc = 0;

  initial begin
    m_done = 1'b0;
    m_rx_data = '0;
    forever begin
      @(negedge clk);
      m_done = 1'b0;
      if (!rst_n) pend = 1'b0;
      if (spur) begin
        m_done = 1'b1;
        m_rx_data = 8'h77;
        spur = 1'b0;
      end else if (pend) begin
        if (cnt == 0) begin
          m_done = 1'b1;
          m_rx_data = m_resp;
          done_cyc = cyc;
          pend = 1'b0;
        end else cnt--;
      end
      if (m_start && m_auto) begin
        pend = 1'b1;
        cnt = m_dly - 1;
      end
    end
  end

  bit prev_start = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) prev_start = 1'b0;
    else begin
      if (m_start) begin
        chk("start_gnt_onehot", $countones(gnt), 1);
        chk("start_single_cycle", prev_start, 0);
      end
      prev_start = m_start;
    end
  end

  int         mptr    = 0;
  logic [7:0] last_rx = '0;

  function automatic int model_pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  function automatic int idx_of(input logic [N-1:0] g);
    for (int i = 0; i < N; i++) if (g[i]) return i;
    return 0;
  endfunction

  task automatic do_xfer(input logic [N-1:0] r, input logic [31:0] txd, input logic [7:0] resp,
                         input int dly, input logic [N-1:0] exp_g, input bit drop);
    logic [7:0] exp_b;
    bit got;
    exp_b = txd[idx_of(exp_g)*8 +: 8];
    @(negedge clk);
    req = r; tx_data = txd; m_resp = resp; m_dly = dly;
    @(negedge clk);
    chk("start_latency", m_start, 1);
    chk("grant", gnt, exp_g);
    chk("m_tx_data", m_tx_data, exp_b);
    chk("busy_start", busy, 1);
    tx_data = ~txd;
    if (drop) req = r & ~exp_g;
    @(negedge clk);
    chk("start_cleared", m_start, 0);
    got = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (ack != 0) begin got = 1'b1; break; end
    end
    chk("ack_seen", got, 1);
    chk("ack_onehot", ack, exp_g);
    chk("ack_latency", cyc - done_cyc, 1);
    chk("gnt_held", gnt, exp_g);
    chk("rx_data", rx_data, resp);
    chk("err_clean", err, 0);
    chk("m_tx_latched", m_tx_data, exp_b);
    req = '0;
    @(negedge clk);
    chk("ack_one_cycle", ack, 0);
    chk("gnt_cleared", gnt, 0);
    chk("busy_cleared", busy, 0);
    mptr = (idx_of(exp_g) + 1) % N;
    last_rx = resp;
  endtask

  typedef struct {
    logic [N-1:0] r;
    logic [7:0]   tx;
    logic [7:0]   resp;
    int           dly;
    logic [N-1:0] exp_g;
  } vec_t;

  vec_t vecs[9];

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"}, gnt, 0);
    chk({tag, "_ack"}, ack, 0);
    chk({tag, "_rx"}, rx_data, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_mstart"}, m_start, 0);
    chk({tag, "_mtx"}, m_tx_data, 0);
  endtask

  initial begin
    logic [N-1:0] r;
    logic [31:0] txd;
    int e, n;
    bit got;

    vecs[0] = '{4'b0001, 8'hA5, 8'h3C, 20, 4'b0001};
    vecs[1] = '{4'b1111, 8'h10, 8'h01, 1,  4'b0010};
    vecs[2] = '{4'b1111, 8'h20, 8'h02, 2,  4'b0100};
    vecs[3] = '{4'b1111, 8'h30, 8'h03, 3,  4'b1000};
    vecs[4] = '{4'b1111, 8'h40, 8'h04, 1,  4'b0001};
    vecs[5] = '{4'b1001, 8'h50, 8'h05, 4,  4'b1000};
    vecs[6] = '{4'b0110, 8'h60, 8'h06, 2,  4'b0010};
    vecs[7] = '{4'b0011, 8'h70, 8'h07, 5,  4'b0001};
    vecs[8] = '{4'b1000, 8'h80, 8'h08, 1,  4'b1000};

    rst_n = 1'b0; req = '0; tx_data = '0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      txd = {vecs[i].tx ^ 8'h33, vecs[i].tx ^ 8'h22, vecs[i].tx ^ 8'h11, vecs[i].tx};
      do_xfer(vecs[i].r, txd, vecs[i].resp, vecs[i].dly, vecs[i].exp_g, 1'b0);
    end

    // Requester 2 drops after grant; requester 3 is next.
    do_xfer(4'b1100, 32'h44332211, 8'hC2, 3, 4'b0100, 1'b1);
    do_xfer(4'b1000, 32'h88776655, 8'hC3, 2, 4'b1000, 1'b0);

    // Spurious m_done in IDLE.
    @(negedge clk);
    spur = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("spur_ack", ack, 0);
    chk("spur_busy", busy, 0);
    chk("spur_gnt", gnt, 0);
    chk("spur_rx", rx_data, last_rx);

    // Reset while BUSY.
    m_auto = 1'b0;
    req = 4'b0001; tx_data = 32'hDEADBEEF;
    @(negedge clk);
    repeat (3) @(negedge clk);
    chk("pre_reset_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("midreset");
    req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    mptr = 0;
    m_auto = 1'b1;
    do_xfer(4'b0010, 32'h0000AB00, 8'h5A, 2, 4'b0010, 1'b0);

    // Master never completes.
    m_auto = 1'b0;
    req = 4'b0100; tx_data = 32'h00CD0000;
    @(negedge clk);
    @(negedge clk);
    chk("stall_grant", gnt, 4'b0100);
    req = '0;
`ifdef SPI_ARB_TIMEOUT_EN
    n = 0; got = 1'b0;
    for (int k = 1; k < 60; k++) begin
      @(negedge clk);
      if (ack != 0) begin got = 1'b1; n = k; break; end
    end
    chk("tmo_ack_seen", got, 1);
    chk("tmo_latency", n, TMO + 1);
    chk("tmo_ack", ack, 4'b0100);
    chk("tmo_err", err, 1);
    chk("tmo_rx", rx_data, 8'hFF);
    @(negedge clk);
    chk("tmo_err_pulse", err, 0);
    chk("tmo_idle", busy, 0);
`else
    got = 1'b0;
    for (int k = 0; k < 3 * TMO; k++) begin
      @(negedge clk);
      if (ack != 0 || err) got = 1'b1;
    end
    chk("stall_no_ack", got, 0);
    chk("stall_busy", busy, 1);
    chk("stall_err", err, 0);
`endif
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    mptr = 0;
    m_auto = 1'b1;

    for (int t = 0; t < 30; t++) begin
      r = N'($urandom_range(1, (1 << N) - 1));
      txd = $urandom;
      e = model_pick(r, mptr);
      do_xfer(r, txd, 8'($urandom), int'($urandom_range(1, 6)), N'(1 << e), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
